// File: rtl/sobel_stream.sv
// ---------------------------------------------------------------------------
// sobel_stream
//   Streaming 3x3 Sobel edge detector. It takes a raster-order grayscale
//   pixel stream and emits one gradient-magnitude pixel for every input
//   pixel. Each output is the Sobel result centred one row up and one column
//   left of the pixel that produced it. The output can be either a saturated
//   magnitude or a binary threshold, selected once per frame. A sticky flag
//   records any line longer than MAX_WIDTH.
//
//   Parameters
//     DATA_W     pixel width in bits (4..16)
//     MAX_WIDTH  maximum pixels per line and line-buffer depth (>= 4)
//
//   Ports
//     aclk, areset              clock, asynchronous active-high reset
//     s_axis_t*                 input pixel stream (tuser = start of frame,
//                               tlast = end of line)
//     m_axis_t*                 output pixel stream with delayed tuser and
//                               tlast
//     cfg_mode, cfg_thresh      0 = magnitude, 1 = threshold. Both are
//                               captured on the start-of-frame beat.
//     err_clr, err_overflow     clear and sticky line-overflow flag
// ---------------------------------------------------------------------------
module sobel_stream #(
    parameter int DATA_W    = 8,
    parameter int MAX_WIDTH = 1024
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tuser,
    input  logic              s_axis_tlast,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tuser,
    output logic              m_axis_tlast,
    input  logic              cfg_mode,
    input  logic [DATA_W+3:0] cfg_thresh,
    input  logic              err_clr,
    output logic              err_overflow
);

    localparam int CW = $clog2(MAX_WIDTH);
    localparam int SW = DATA_W + 2;
    localparam int GW = DATA_W + 3;
    localparam int MW = DATA_W + 4;
    localparam logic [CW-1:0] COL_LAST = CW'(MAX_WIDTH - 1);

    logic              ce;
    logic              accept;

    logic [CW-1:0]     col;
    logic [1:0]        row;
    logic              line_ovf;
    logic              mode_q;
    logic [MW-1:0]     thresh_q;

    logic [CW-1:0]     beat_col;
    logic [1:0]        beat_row;
    logic              beat_ovf;
    logic              beat_mode;
    logic [MW-1:0]     beat_thresh;
    logic              beat_border;

    logic [DATA_W-1:0] line_buf1 [MAX_WIDTH];
    logic [DATA_W-1:0] line_buf2 [MAX_WIDTH];
    logic [DATA_W-1:0] lb1_rd;
    logic [DATA_W-1:0] lb2_rd;

    logic [DATA_W-1:0] win [3][3];
    logic              s1_valid;
    logic              s1_user;
    logic              s1_last;
    logic              s1_border;
    logic              s1_mode;
    logic [MW-1:0]     s1_thresh;

    logic [SW-1:0]     sum_left;
    logic [SW-1:0]     sum_right;
    logic [SW-1:0]     sum_top;
    logic [SW-1:0]     sum_bottom;
    logic [GW-1:0]     gx_next;
    logic [GW-1:0]     gy_next;

    logic              s2_valid;
    logic              s2_user;
    logic              s2_last;
    logic              s2_border;
    logic              s2_mode;
    logic [MW-1:0]     s2_thresh;
    logic [GW-1:0]     s2_gx;
    logic [GW-1:0]     s2_gy;

    logic [GW-1:0]     gx_abs;
    logic [GW-1:0]     gy_abs;
    logic [MW-1:0]     mag;
    logic [DATA_W-1:0] result;

    // The whole pipeline moves as one unit. It advances whenever the
    // output register is empty or is being drained, and the input is
    // ready under the same condition.
    assign ce            = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = ce;
    assign accept        = s_axis_tvalid && ce;

    // Work out where the incoming beat sits in the frame. A start-of-frame
    // beat restarts the position at (0,0) and brings in the live config.
    // Every other beat uses the config captured at the last frame start.
    // Anything in the first two rows or columns, or past the end of an
    // overlong line, is border and produces zero.
    always_comb begin
        beat_col    = s_axis_tuser ? '0 : col;
        beat_row    = s_axis_tuser ? 2'd0 : row;
        beat_ovf    = line_ovf && !s_axis_tuser;
        beat_mode   = s_axis_tuser ? cfg_mode : mode_q;
        beat_thresh = s_axis_tuser ? cfg_thresh : thresh_q;
        beat_border = (beat_row != 2'd2) || (beat_col[CW-1:1] == '0) || beat_ovf;
    end

    // The two line buffers are read at the beat's column. The values read
    // are the pixels directly above the beat (row r-1) and two rows above
    // it (row r-2).
    assign lb1_rd = line_buf1[beat_col];
    assign lb2_rd = line_buf2[beat_col];

    // Line buffer update. The new pixel replaces row r-1 at this column,
    // and the old row r-1 value moves down into row r-2. Beats past the end
    // of an overlong line do not write, so the buffers keep the last valid
    // column.
    always_ff @(posedge aclk) begin
        if (accept && !beat_ovf) begin
            line_buf1[beat_col] <= s_axis_tdata;
            line_buf2[beat_col] <= lb1_rd;
        end
    end

    // Position tracking. col holds the column the next beat will take, and
    // row holds the next beat's row, saturating at 2. Only "at least two
    // rows in" matters. When a line runs past MAX_WIDTH, the column sticks
    // at the last buffer slot and line_ovf marks the rest of the line as
    // overflow until tlast. The config is captured on the frame-start beat.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            col      <= '0;
            row      <= 2'd0;
            line_ovf <= 1'b0;
            mode_q   <= 1'b0;
            thresh_q <= '0;
        end else if (accept) begin
            if (s_axis_tuser) begin
                mode_q   <= cfg_mode;
                thresh_q <= cfg_thresh;
            end
            if (s_axis_tlast) begin
                col      <= '0;
                line_ovf <= 1'b0;
                row      <= (beat_row == 2'd2) ? 2'd2 : beat_row + 2'd1;
            end else begin
                row <= beat_row;
                if (beat_ovf || beat_col == COL_LAST) begin
                    col      <= COL_LAST;
                    line_ovf <= 1'b1;
                end else begin
                    col      <= beat_col + CW'(1);
                    line_ovf <= 1'b0;
                end
            end
        end
    end

    // Sticky overflow flag. It is set by accepting a beat beyond the end of
    // the line buffer. A new overflow beats a simultaneous clear.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            err_overflow <= 1'b0;
        end else if (accept && beat_ovf) begin
            err_overflow <= 1'b1;
        end else if (err_clr) begin
            err_overflow <= 1'b0;
        end
    end

    // Column and row weighted sums (1,2,1) of the window, and the two
    // gradients. Each gradient is computed as a wrap-around difference in
    // GW bits, which gives the signed value in two's complement.
    always_comb begin
        sum_right  = {2'b00, win[0][2]} + {1'b0, win[1][2], 1'b0} + {2'b00, win[2][2]};
        sum_left   = {2'b00, win[0][0]} + {1'b0, win[1][0], 1'b0} + {2'b00, win[2][0]};
        sum_bottom = {2'b00, win[2][0]} + {1'b0, win[2][1], 1'b0} + {2'b00, win[2][2]};
        sum_top    = {2'b00, win[0][0]} + {1'b0, win[0][1], 1'b0} + {2'b00, win[0][2]};
        gx_next    = {1'b0, sum_right} - {1'b0, sum_left};
        gy_next    = {1'b0, sum_bottom} - {1'b0, sum_top};
    end

    // Magnitude and output mapping. Border beats always give zero. Mode 1
    // compares the magnitude against the frame's threshold. Mode 0 clips
    // the magnitude to the pixel range.
    always_comb begin
        gx_abs = s2_gx[GW-1] ? (~s2_gx + GW'(1)) : s2_gx;
        gy_abs = s2_gy[GW-1] ? (~s2_gy + GW'(1)) : s2_gy;
        mag    = MW'(gx_abs) + MW'(gy_abs);
        if (s2_border) begin
            result = '0;
        end else if (s2_mode) begin
            result = (mag >= s2_thresh) ? '1 : '0;
        end else if (mag[MW-1:DATA_W] != '0) begin
            result = '1;
        end else begin
            result = mag[DATA_W-1:0];
        end
    end

    // The three pipeline stages, all gated by the global enable.
    //   S1: the window shifts left, and a new column (row r-2, row r-1 and
    //       the live pixel) enters on the right.
    //   S2: the gradients are registered.
    //   S3: the output register is loaded.
    // Each stage carries the beat's sideband, border flag and config, so a
    // config change at a frame start never affects beats still in flight.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win[i][j] <= '0;
                end
            end
            s1_valid      <= 1'b0;
            s1_user       <= 1'b0;
            s1_last       <= 1'b0;
            s1_border     <= 1'b1;
            s1_mode       <= 1'b0;
            s1_thresh     <= '0;
            s2_valid      <= 1'b0;
            s2_user       <= 1'b0;
            s2_last       <= 1'b0;
            s2_border     <= 1'b1;
            s2_mode       <= 1'b0;
            s2_thresh     <= '0;
            s2_gx         <= '0;
            s2_gy         <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else if (ce) begin
            s1_valid <= s_axis_tvalid;
            if (s_axis_tvalid) begin
                for (int i = 0; i < 3; i++) begin
                    win[i][0] <= win[i][1];
                    win[i][1] <= win[i][2];
                end
                win[0][2] <= lb2_rd;
                win[1][2] <= lb1_rd;
                win[2][2] <= s_axis_tdata;
                s1_user   <= s_axis_tuser;
                s1_last   <= s_axis_tlast;
                s1_border <= beat_border;
                s1_mode   <= beat_mode;
                s1_thresh <= beat_thresh;
            end

            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_gx     <= gx_next;
                s2_gy     <= gy_next;
                s2_user   <= s1_user;
                s2_last   <= s1_last;
                s2_border <= s1_border;
                s2_mode   <= s1_mode;
                s2_thresh <= s1_thresh;
            end

            m_axis_tvalid <= s2_valid;
            if (s2_valid) begin
                m_axis_tdata <= result;
                m_axis_tuser <= s2_user;
                m_axis_tlast <= s2_last;
            end
        end
    end

endmodule

// File: tb/tb_sobel_stream.sv
// ---------------------------------------------------------------------------
// tb_sobel_stream
//   Testbench for sobel_stream with DATA_W=8 and MAX_WIDTH=16. Each frame is
//   held as a 2D image. The expected output for every beat is computed
//   directly from the image neighbourhood, and a single compare process
//   checks every output transfer against that queue. The input side can
//   insert random gaps, and the output side can apply random back-pressure.
// ---------------------------------------------------------------------------
module tb_sobel_stream;

    localparam int DW   = 8;
    localparam int MAXW = 16;

    typedef struct {
        int data;
        bit user;
        bit last;
    } exp_t;

    logic          aclk;
    logic          areset;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tuser;
    logic          s_axis_tlast;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tuser;
    logic          m_axis_tlast;
    logic          cfg_mode;
    logic [DW+3:0] cfg_thresh;
    logic          err_clr;
    logic          err_overflow;

    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    int   first_accept_cyc = 0;
    int   first_valid_cyc = 0;
    bit   latch_first = 0;
    bit   gaps_on = 0;
    bit   ready_random = 0;
    int   img [8][32];
    exp_t exp_q [$];
    int   got_q [$];

    sobel_stream #(
        .DATA_W   (DW),
        .MAX_WIDTH(MAXW)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tuser (s_axis_tuser),
        .s_axis_tlast (s_axis_tlast),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tlast (m_axis_tlast),
        .cfg_mode     (cfg_mode),
        .cfg_thresh   (cfg_thresh),
        .err_clr      (err_clr),
        .err_overflow (err_overflow)
    );

    // 10-unit clock period
    initial begin
        aclk = 0;
        forever #5 aclk = ~aclk;
    end

    // Free-running cycle count, used for the latency measurement
    always @(posedge aclk) cyc <= cyc + 1;

    // Downstream back-pressure. The ready is either held high or
    // re-randomised just after every edge.
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            m_axis_tready = ready_random ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // One comparison with a pass/fail record
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Reference Sobel for the beat at (r,c), centred on (r-1,c-1) of the
    // image currently held in img
    function automatic int sobelRef(input int r, input int c, input bit mode, input int thresh);
        int gx;
        int gy;
        int mag;
        if (r < 2 || c < 2 || c >= MAXW) return 0;
        gx = (img[r-2][c] + 2 * img[r-1][c] + img[r][c])
           - (img[r-2][c-2] + 2 * img[r-1][c-2] + img[r][c-2]);
        gy = (img[r][c-2] + 2 * img[r][c-1] + img[r][c])
           - (img[r-2][c-2] + 2 * img[r-2][c-1] + img[r-2][c]);
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (mode) return (mag >= thresh) ? 255 : 0;
        return (mag > 255) ? 255 : mag;
    endfunction

    // Compare process. At the falling edge it checks the ready rule and any
    // output transfer that the next rising edge will complete.
    always @(negedge aclk) begin
        exp_t e;
        if (!areset) begin
            checkOutput("readyRule", s_axis_tready, !(m_axis_tvalid && !m_axis_tready));
            if (latch_first && m_axis_tvalid) begin
                first_valid_cyc = cyc;
                latch_first = 0;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpectedBeat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput($sformatf("data[%0d]", got_q.size()), m_axis_tdata, e.data);
                    checkOutput($sformatf("user[%0d]", got_q.size()), m_axis_tuser, e.user);
                    checkOutput($sformatf("last[%0d]", got_q.size()), m_axis_tlast, e.last);
                    got_q.push_back(int'(m_axis_tdata));
                end
            end
        end
    end

    // Present one beat and hold it until accepted. The task is entered and
    // left just after a rising edge.
    task automatic driveBeat(input int d, input bit u, input bit l, output int acc_cyc);
        int waited = 0;
        bit ok = 0;
        acc_cyc = 0;
        if (gaps_on) begin
            while ($urandom_range(0, 3) == 0) begin
                @(posedge aclk);
                #1;
            end
        end
        s_axis_tdata  = d[DW-1:0];
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        while (!ok && waited < 1000) begin
            @(negedge aclk);
            if (s_axis_tready) begin
                ok = 1;
                acc_cyc = cyc;
            end
            @(posedge aclk);
            #1;
            waited++;
        end
        s_axis_tvalid = 1'b0;
        if (!ok) checkOutput("acceptTimeout", 0, 1);
    endtask

    // Build a frame, queue its expected outputs and stream it in.
    // Patterns: 0 constant 100, 1 horizontal ramp, 2 vertical step, 3 random.
    // If stop_after >= 0, only that many beats are sent.
    task automatic applyStimulus(input int pattern, input int rows, input int cols,
                                 input bit mode, input int thresh, input int stop_after);
        exp_t e;
        int acc_cyc;
        int n = 0;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                case (pattern)
                    0:       img[r][c] = 100;
                    1:       img[r][c] = (10 * c) % 256;
                    2:       img[r][c] = (c >= 4) ? 255 : 0;
                    default: img[r][c] = $urandom_range(0, 255);
                endcase
            end
        end
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                e.data = sobelRef(r, c, mode, thresh);
                e.user = (r == 0 && c == 0);
                e.last = (c == cols - 1);
                exp_q.push_back(e);
            end
        end
        got_q.delete();
        cfg_mode   = mode;
        cfg_thresh = 12'(thresh);
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                if (stop_after >= 0 && n >= stop_after) return;
                if (r == 0 && c == MAXW + 1) err_clr = 1'b1;
                driveBeat(img[r][c], (r == 0 && c == 0), (c == cols - 1), acc_cyc);
                err_clr = 1'b0;
                if (n == 0) begin
                    first_accept_cyc = acc_cyc;
                    cfg_mode   = 1'($urandom_range(0, 1));
                    cfg_thresh = 12'($urandom_range(0, 4095));
                end
                if (r == 0 && c == MAXW - 1) checkOutput("ovfBefore", err_overflow, 0);
                if (r == 0 && c == MAXW)     checkOutput("ovfRise", err_overflow, 1);
                if (r == 0 && c == MAXW + 1) checkOutput("ovfSetWins", err_overflow, 1);
                n++;
            end
        end
    endtask

    // Wait, with a bound, for every queued expectation to be consumed
    task automatic waitDrain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge aclk);
            n++;
        end
        @(posedge aclk);
        #1;
        checkOutput("drained", exp_q.size(), 0);
    endtask

    initial begin
        areset        = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
        cfg_mode      = 1'b0;
        cfg_thresh    = '0;
        err_clr       = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        checkOutput("rstTvalid", m_axis_tvalid, 0);
        checkOutput("rstTdata", m_axis_tdata, 0);
        checkOutput("rstTuser", m_axis_tuser, 0);
        checkOutput("rstTlast", m_axis_tlast, 0);
        checkOutput("rstErr", err_overflow, 0);
        checkOutput("rstSready", s_axis_tready, 1);
        areset = 1'b0;
        @(posedge aclk);
        #1;

        applyStimulus(0, 8, 8, 0, 0, -1);
        waitDrain();
        checkOutput("constCount", got_q.size(), 64);

        latch_first = 1;
        applyStimulus(1, 8, 8, 0, 0, -1);
        waitDrain();
        checkOutput("latency", first_valid_cyc - first_accept_cyc, 3);
        checkOutput("modelRamp22", sobelRef(2, 2, 0, 0), 80);
        checkOutput("modelRamp14", sobelRef(1, 4, 0, 0), 0);
        checkOutput("rampOut22", got_q[2*8+2], 80);
        checkOutput("rampOut57", got_q[5*8+7], 80);
        checkOutput("rampOut21", got_q[2*8+1], 0);

        applyStimulus(2, 8, 8, 0, 0, -1);
        waitDrain();
        checkOutput("modelStep34", sobelRef(3, 4, 0, 0), 255);
        checkOutput("modelStep36", sobelRef(3, 6, 0, 0), 0);
        checkOutput("modelStepT500", sobelRef(3, 5, 1, 500), 255);
        checkOutput("modelStepT1021", sobelRef(3, 4, 1, 1021), 0);
        checkOutput("stepOut34", got_q[3*8+4], 255);
        checkOutput("stepOut35", got_q[3*8+5], 255);
        checkOutput("stepOut36", got_q[3*8+6], 0);

        applyStimulus(2, 8, 8, 1, 500, -1);
        waitDrain();
        checkOutput("stepT500Out44", got_q[4*8+4], 255);

        applyStimulus(2, 8, 8, 1, 1021, -1);
        waitDrain();
        checkOutput("stepT1021Out44", got_q[4*8+4], 0);

        gaps_on      = 1;
        ready_random = 1;
        applyStimulus(2, 8, 8, 0, 0, -1);
        waitDrain();
        checkOutput("stepBpCount", got_q.size(), 64);
        checkOutput("stepBpOut25", got_q[2*8+5], 255);

        for (int k = 0; k < 4; k++) begin
            applyStimulus(3, 4 + $urandom_range(0, 4), 5 + $urandom_range(0, 11),
                          1'($urandom_range(0, 1)), $urandom_range(0, 2100), -1);
            waitDrain();
        end

        applyStimulus(3, 3, 20, 0, 0, -1);
        waitDrain();
        checkOutput("ovfOut0_17", got_q[17], 0);
        checkOutput("errSticky", err_overflow, 1);
        err_clr = 1'b1;
        @(posedge aclk);
        #1;
        err_clr = 1'b0;
        checkOutput("errCleared", err_overflow, 0);

        gaps_on      = 0;
        ready_random = 0;
        applyStimulus(3, 1, 18, 0, 0, -1);
        waitDrain();
        applyStimulus(2, 8, 8, 0, 0, 3*8+2);
        areset = 1'b1;
        #1;
        checkOutput("midRstTvalid", m_axis_tvalid, 0);
        checkOutput("midRstErr", err_overflow, 0);
        checkOutput("midRstSready", s_axis_tready, 1);
        exp_q.delete();
        repeat (3) @(posedge aclk);
        #1;
        areset = 1'b0;
        @(posedge aclk);
        #1;

        applyStimulus(2, 8, 8, 0, 0, -1);
        waitDrain();
        checkOutput("postRstCount", got_q.size(), 64);
        checkOutput("postRstOut34", got_q[3*8+4], 255);
        checkOutput("postRstOut24", got_q[2*8+4], 255);
        checkOutput("postRstOut14", got_q[1*8+4], 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/sobel_stream.md
# sobel_stream

Parametrised streaming Sobel edge-detection core, the successor to the fixed AXI4 memory-mapped Sobel IP. Accepts a raster-order grayscale pixel stream on an AXI4-Stream slave and emits one gradient-magnitude pixel per input pixel on an AXI4-Stream master. Supports configurable pixel width and maximum line length, a runtime-selectable magnitude or binary-threshold mode, and sticky line-overflow detection. Sits between the video DMA read channel and the write-back DMA.

## Interface
- DATA_W, 8, pixel width in bits (4..16)
- MAX_WIDTH, 1024, maximum pixels per line; sets line-buffer depth
- aclk  in  1  clock; all logic is on the rising edge
- areset  in  1  asynchronous, active-high reset
- s_axis_tdata  in  DATA_W  input pixel
- s_axis_tvalid  in  1  input beat valid
- s_axis_tready  out  1  input beat accepted when tvalid && tready
- s_axis_tuser  in  1  start of frame; first pixel of row 0
- s_axis_tlast  in  1  last pixel of a line
- m_axis_tdata  out  DATA_W  output pixel
- m_axis_tvalid, m_axis_tready, m_axis_tuser, m_axis_tlast  out/in/out/out  1 each  output stream handshake and sideband
- cfg_mode  in  1  0 = saturated magnitude, 1 = binary threshold
- cfg_thresh  in  DATA_W+4  threshold for mode 1
- err_clr  in  1  clears err_overflow
- err_overflow  out  1  sticky: a line exceeded MAX_WIDTH

## Operation
- Two line buffers of depth MAX_WIDTH × DATA_W hold rows r-1 and r-2, addressed by the column counter (col). A 3×3 shift-register window holds columns c-2..c of rows r-2..r.
- col: cleared on acceptance of a tuser beat or the beat after a tlast beat; otherwise incremented per accepted beat. row: cleared on tuser, incremented after each tlast, saturating at 2. Only row<2 matters.
- Output beat k corresponds to input beat k. Its value is the Sobel result centred at input (row-1, col-1); the output image is shifted one row and one column.
- Gx = (p[0][2] + 2·p[1][2] + p[2][2]) − (p[0][0] + 2·p[1][0] + p[2][0]); Gy is the same with rows and columns swapped. Both are signed, DATA_W+3 bits.
- mag = |Gx| + |Gy|, unsigned, DATA_W+4 bits; maximum 8·(2^DATA_W − 1), no overflow.
- Mode 0: tdata = min(mag, 2^DATA_W − 1). Mode 1: tdata = all-ones if mag ≥ cfg_thresh, else 0.
- Border: if row<2 or col<2 at the input beat, tdata = 0 in either mode.
- m_axis_tuser and m_axis_tlast are the input's values for the same beat, delayed with the data.
- cfg_mode and cfg_thresh are sampled on acceptance of a tuser beat and held for the whole frame.
- Overflow: if col reaches MAX_WIDTH without tlast, err_overflow is set. col then holds at MAX_WIDTH-1, line-buffer writes are suppressed, output for those beats is 0, and tlast is still forwarded. err_overflow clears only on err_clr or reset; if err_clr and a new overflow occur in the same cycle, set wins.
- No frame-end flush: the last row and column of centres are never produced.

## Timing
- Pipeline of 3 stages: S1 window/line-buffer update, S2 Gx/Gy, S3 magnitude/mode to the output register. Each stage has its own valid bit; bubbles propagate.
- Global enable ce = !m_axis_tvalid || m_axis_tready. All stages advance only when ce is high. s_axis_tready = ce (combinational).
- Latency: an accepted beat appears on m_axis_tvalid 3 cycles later with m_axis_tready held high. Throughput is 1 pixel per cycle.
- Output stability: while m_axis_tvalid && !m_axis_tready, m_axis_tdata, tuser and tlast hold.
- Reset (async assert, sync release): every stage valid = 0; m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast, err_overflow, col, row, cfg registers = 0. s_axis_tready reads 1 during and after reset.
- Line-buffer contents are not reset. row=0 after reset forces border output until a full frame start.
- Reset mid-frame: in-flight beats are discarded. Output is correct from the next tuser beat.

## Test plan
- DATA_W=8, MAX_WIDTH=16, 8×8 frame of constant 100, mode 0 -> 64 output beats, all 0; tuser on beat 1; tlast on beats 8, 16, …, 64.
- 8×8 horizontal ramp p=10·col, mode 0 -> output 80 where row≥2 and col≥2, 0 elsewhere; first output 3 cycles after first accept.
- 8×8 vertical step (cols 0-3 = 0, cols 4-7 = 255) -> mode 0: 255 at cols 4,5 of rows ≥2, 0 elsewhere. Mode 1, thresh=500: same pattern. Mode 1, thresh=1021: all 0 (mag=1020). A cfg change mid-frame takes no effect until the next tuser.
- Step image with m_axis_tready randomly 50% low -> identical output sequence, no lost or duplicated beats; s_axis_tready=0 exactly when m_axis_tvalid && !m_axis_tready.
- 20-pixel line with MAX_WIDTH=16 -> err_overflow rises on the 17th accepted beat; outputs for beats 17-20 are 0; tlast is forwarded on beat 20; err_clr pulse -> err_overflow=0 next cycle.
- areset asserted during row 3 of a frame -> m_axis_tvalid=0 immediately, err_overflow=0; a following step-image frame with tuser reproduces the step-image mode 0 result exactly.
